// File: rtl/rx_frame_parser_pkg.sv
// Shared constants, state encoding and checksum helper for the UART command-frame parser.
package rx_frame_parser_pkg;

   localparam int         GAP_CYCLES_DEF = 7680;
   localparam logic [7:0] HDR_BYTE_DEF   = 8'hAA;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_CHK  = 2'b01;
   localparam logic [1:0] ERR_GAP  = 2'b10;

   // Each state names the byte the parser is waiting for next.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CMD  = 3'd1,
      S_ARGH = 3'd2,
      S_ARGL = 3'd3,
      S_CHK  = 3'd4
   } state_t;

   function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/rx_frame_parser_if.sv
// Byte-in / decoded-frame-out bundle between the UART receiver, the parser and driver control.
interface rx_frame_parser_if;
   logic [7:0]  Rx_Data;
   logic        Rx_Done_Sig;
   logic        Rx_En_Sig;
   logic [7:0]  Frame_Cmd;
   logic [15:0] Frame_Arg;
   logic        Frame_Valid;
   logic        Frame_Err;
   logic [1:0]  Err_Code;

   modport slave (
      input  Rx_Data, Rx_Done_Sig,
      output Rx_En_Sig, Frame_Cmd, Frame_Arg, Frame_Valid, Frame_Err, Err_Code
   );

   modport master (
      output Rx_Data, Rx_Done_Sig,
      input  Rx_En_Sig, Frame_Cmd, Frame_Arg, Frame_Valid, Frame_Err, Err_Code
   );
endinterface

// File: rtl/rx_gap_timer.sv
// Inter-byte gap timer: counts cycles since the last clear while run is high and
// flags expire during the cycle before the GAP_CYCLES-th edge.
module rx_gap_timer #(
   parameter int GAP_CYCLES = 7680
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expire
);

   localparam int CNT_W = $clog2(GAP_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expire = run && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear || !run) begin
         cnt_d = '0;
      end else if (!expire) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rx_frame_parser.sv
// Assembles HDR/CMD/ARG_H/ARG_L/CHK frames from UART bytes, validates checksum and
// inter-byte gap, and publishes a decoded command or an error strobe with cause.
module rx_frame_parser
   import rx_frame_parser_pkg::*;
#(
   parameter int         GAP_CYCLES = GAP_CYCLES_DEF,
   parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEF
) (
   input logic              clk,
   input logic              reset,
   rx_frame_parser_if.slave rx
);

   state_t      state_q, state_d;
   logic [7:0]  cmd_sh_q, cmd_sh_d;
   logic [15:0] arg_sh_q, arg_sh_d;
   logic [7:0]  sum_q, sum_d;
   logic [7:0]  frame_cmd_q, frame_cmd_d;
   logic [15:0] frame_arg_q, frame_arg_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic [1:0]  err_code_q, err_code_d;
   logic        rx_en_q, rx_en_d;
   logic        gap_run;
   logic        gap_expire;

   assign gap_run = (state_q != S_IDLE);

   rx_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (rx.Rx_Done_Sig),
      .run    (gap_run),
      .expire (gap_expire)
   );

   // A byte arriving on the expiry cycle takes priority over the timeout.
   always_comb begin
      state_d     = state_q;
      cmd_sh_d    = cmd_sh_q;
      arg_sh_d    = arg_sh_q;
      sum_d       = sum_q;
      frame_cmd_d = frame_cmd_q;
      frame_arg_d = frame_arg_q;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      rx_en_d     = 1'b1;

      if (rx.Rx_Done_Sig) begin
         case (state_q)
            S_IDLE: begin
               if (rx.Rx_Data == HDR_BYTE) state_d = S_CMD;
            end
            S_CMD: begin
               cmd_sh_d = rx.Rx_Data;
               sum_d    = sum_add(sum_q, rx.Rx_Data);
               state_d  = S_ARGH;
            end
            S_ARGH: begin
               arg_sh_d[15:8] = rx.Rx_Data;
               sum_d          = sum_add(sum_q, rx.Rx_Data);
               state_d        = S_ARGL;
            end
            S_ARGL: begin
               arg_sh_d[7:0] = rx.Rx_Data;
               sum_d         = sum_add(sum_q, rx.Rx_Data);
               state_d       = S_CHK;
            end
            S_CHK: begin
               if (rx.Rx_Data == sum_q) begin
                  frame_cmd_d = cmd_sh_q;
                  frame_arg_d = arg_sh_q;
                  valid_d     = 1'b1;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = ERR_CHK;
               end
               cmd_sh_d = '0;
               arg_sh_d = '0;
               sum_d    = '0;
               state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end else if (gap_expire) begin
         err_d      = 1'b1;
         err_code_d = ERR_GAP;
         cmd_sh_d   = '0;
         arg_sh_d   = '0;
         sum_d      = '0;
         state_d    = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cmd_sh_q    <= '0;
         arg_sh_q    <= '0;
         sum_q       <= '0;
         frame_cmd_q <= '0;
         frame_arg_q <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
         rx_en_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_sh_q    <= cmd_sh_d;
         arg_sh_q    <= arg_sh_d;
         sum_q       <= sum_d;
         frame_cmd_q <= frame_cmd_d;
         frame_arg_q <= frame_arg_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         rx_en_q     <= rx_en_d;
      end
   end

   assign rx.Rx_En_Sig   = rx_en_q;
   assign rx.Frame_Cmd   = frame_cmd_q;
   assign rx.Frame_Arg   = frame_arg_q;
   assign rx.Frame_Valid = valid_q;
   assign rx.Frame_Err   = err_q;
   assign rx.Err_Code    = err_code_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Scoreboard bench for rx_frame_parser: directed frames plus randomized byte streams
// checked against a byte-list reference model.
module tb_rx_frame_parser;
   import rx_frame_parser_pkg::*;

   localparam int GAP = 7680;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   rx_frame_parser_if bus();

   rx_frame_parser #(.GAP_CYCLES(GAP), .HDR_BYTE(8'hAA)) dut (
      .clk   (clk),
      .reset (reset),
      .rx    (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   typedef struct {
      bit          err;
      logic [7:0]  cmd;
      logic [15:0] arg;
      logic [1:0]  code;
      int          at;
   } exp_t;

   exp_t sb[$];

   // reference model state
   bit          in_frame = 1'b0;
   logic [7:0]  part[$];
   int          last_edge = 0;
   logic [7:0]  m_cmd = 8'h00;
   logic [15:0] m_arg = 16'h0000;
   logic [1:0]  m_code = 2'b00;
   bit          mon_en = 1'b0;

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h cycle=%0d", name, got, want, cyc);
      end
   endtask

   function automatic void push_ev(input bit err, input int at);
      exp_t e;
      e.err  = err;
      e.cmd  = m_cmd;
      e.arg  = m_arg;
      e.code = m_code;
      e.at   = at;
      sb.push_back(e);
   endfunction

   task automatic model_byte(input logic [7:0] b, input int edge_n);
      if (!in_frame) begin
         if (b == 8'hAA) begin
            in_frame = 1'b1;
            part.delete();
         end
      end else begin
         part.push_back(b);
         if (part.size() == 4) begin
            int s;
            s = (int'(part[0]) + int'(part[1]) + int'(part[2])) % 256;
            if (int'(part[3]) == s) begin
               m_cmd = part[0];
               m_arg = {part[1], part[2]};
               push_ev(1'b0, edge_n);
            end else begin
               m_code = 2'b01;
               push_ev(1'b1, edge_n);
            end
            in_frame = 1'b0;
         end
      end
      last_edge = edge_n;
   endtask

   task automatic strobe(input logic [7:0] b);
      @(negedge clk);
      bus.Rx_Data     = b;
      bus.Rx_Done_Sig = 1'b1;
      model_byte(b, cyc + 1);
   endtask

   task automatic quiet(input int k);
      repeat (k) begin
         @(negedge clk);
         bus.Rx_Done_Sig = 1'b0;
         if (in_frame && (cyc + 1 - last_edge == GAP)) begin
            m_code = 2'b10;
            push_ev(1'b1, cyc + 1);
            in_frame = 1'b0;
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [15:0] a, input logic [7:0] ck);
      strobe(8'hAA);
      strobe(c);
      strobe(a[15:8]);
      strobe(a[7:0]);
      strobe(ck);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.Rx_Done_Sig = 1'b0;
      reset = 1'b0;
      in_frame = 1'b0;
      part.delete();
      m_cmd = 8'h00;
      m_arg = 16'h0000;
      m_code = 2'b00;
      #1;
      chk("rst_rx_en", int'(bus.Rx_En_Sig), 0);
      chk("rst_cmd", int'(bus.Frame_Cmd), 0);
      chk("rst_arg", int'(bus.Frame_Arg), 0);
      chk("rst_valid", int'(bus.Frame_Valid), 0);
      chk("rst_err", int'(bus.Frame_Err), 0);
      chk("rst_code", int'(bus.Err_Code), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      mon_en = 1'b1;
      #1;
      chk("rx_en_before_edge", int'(bus.Rx_En_Sig), 0);
      @(negedge clk);
      chk("rx_en_after_edge", int'(bus.Rx_En_Sig), 1);
   endtask

   // monitor: every strobe must match the oldest expected event
   exp_t mon_e;
   always @(negedge clk) begin
      if (mon_en && reset === 1'b1) begin
         if (bus.Frame_Valid && bus.Frame_Err) chk("both_strobes", 1, 0);
         if (bus.Frame_Valid || bus.Frame_Err) begin
            if (sb.size() == 0) begin
               chk("unexpected_strobe", int'({bus.Frame_Err, bus.Frame_Valid}), 0);
            end else begin
               mon_e = sb.pop_front();
               chk("kind_err", int'(bus.Frame_Err), int'(mon_e.err));
               chk("when", cyc, mon_e.at);
               chk("cmd", int'(bus.Frame_Cmd), int'(mon_e.cmd));
               chk("arg", int'(bus.Frame_Arg), int'(mon_e.arg));
               chk("code", int'(bus.Err_Code), int'(mon_e.code));
            end
         end
      end
   end

   initial begin
      logic [7:0]  c, ah, al, ck, j;
      int          nj, gap;
      bus.Rx_Data     = 8'h00;
      bus.Rx_Done_Sig = 1'b0;

      do_reset();

      send_frame(8'h01, 16'h1234, 8'h47);
      quiet(2);
      send_frame(8'h01, 16'h1234, 8'h48);
      quiet(2);
      strobe(8'h55);
      strobe(8'h00);
      send_frame(8'h80, 16'h90F0, 8'h00);
      quiet(3);

      strobe(8'hAA);
      strobe(8'h01);
      quiet(GAP + 5);
      send_frame(8'h02, 16'h0000, 8'h02);
      quiet(3);

      strobe(8'hAA);
      strobe(8'h05);
      quiet(GAP - 1);
      strobe(8'h10);
      strobe(8'h20);
      strobe(8'h35);
      quiet(3);

      strobe(8'hAA);
      strobe(8'h01);
      strobe(8'h12);
      do_reset();
      send_frame(8'h03, 16'h0001, 8'h04);
      quiet(3);

      for (int i = 0; i < 40; i++) begin
         nj = $urandom_range(0, 2);
         for (int k = 0; k < nj; k++) begin
            j = 8'($urandom_range(0, 255));
            if (j == 8'hAA) j = 8'h55;
            strobe(j);
         end
         quiet($urandom_range(0, 2));
         c  = 8'($urandom_range(0, 255));
         ah = 8'($urandom_range(0, 255));
         al = 8'($urandom_range(0, 255));
         ck = 8'((int'(c) + int'(ah) + int'(al)) % 256);
         if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
         for (int k = 0; k < 5; k++) begin
            case (k)
               0: strobe(8'hAA);
               1: strobe(c);
               2: strobe(ah);
               3: strobe(al);
               default: strobe(ck);
            endcase
            if ((i % 13 == 6) && (k == 2)) gap = (i % 2 == 0) ? GAP - 1 : GAP;
            else gap = $urandom_range(0, 2);
            quiet(gap);
         end
      end

      quiet(GAP + 10);
      chk("sb_empty", sb.size(), 0);
      chk("final_cmd", int'(bus.Frame_Cmd), int'(m_cmd));
      chk("final_arg", int'(bus.Frame_Arg), int'(m_arg));
      chk("final_code", int'(bus.Err_Code), int'(m_code));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rx_frame_parser.md
# rx_frame_parser

Byte-to-command framing stage placed directly downstream of the UART receiver. Consumes each received byte and its done strobe, assembles fixed 5-byte command frames (header, command, 16-bit argument, checksum), and validates the checksum and inter-byte gap. Publishes a decoded command/argument pair with a one-cycle valid strobe, or an error strobe with a cause code, to the driver control logic.

## Interface
Parameters:
- GAP_CYCLES, 7680: inter-byte timeout in clk cycles (3 byte-times at 9600 baud, 2.4576 MHz)
- HDR_BYTE, 8'hAA: frame header value

Ports:
- clk  input  1  system clock, 2.4576 MHz
- reset  input  1  asynchronous, active-low reset
- Rx_Data  input  8  byte from UART receiver, valid while Rx_Done_Sig is high
- Rx_Done_Sig  input  1  one-cycle pulse per received byte
- Rx_En_Sig  output  1  receive enable to UART receiver
- Frame_Cmd  output  8  command byte of last good frame
- Frame_Arg  output  16  argument of last good frame, {ARG_H, ARG_L}
- Frame_Valid  output  1  one-cycle pulse, good frame published
- Frame_Err  output  1  one-cycle pulse, frame discarded
- Err_Code  output  2  cause of last error: 2'b01 checksum, 2'b10 timeout

## Operation
- Frame: HDR_BYTE, CMD, ARG_H, ARG_L, CHK; CHK = (CMD + ARG_H + ARG_L) mod 256, 8-bit wrap-around sum.
- States: S_IDLE, S_CMD, S_ARGH, S_ARGL, S_CHK.
- S_IDLE: byte == HDR_BYTE -> S_CMD; any other byte discarded silently, no error.
- S_CMD/S_ARGH/S_ARGL: capture byte into shadow registers, accumulate sum, advance. HDR_BYTE inside a frame is ordinary data; no resync.
- S_CHK: byte == sum -> load Frame_Cmd/Frame_Arg from shadows, pulse Frame_Valid; else pulse Frame_Err, Err_Code=01, outputs unchanged. Both cases -> S_IDLE.
- Gap timer: counts cycles since last Rx_Done_Sig while state != S_IDLE; reaching GAP_CYCLES -> Frame_Err pulse, Err_Code=10, -> S_IDLE, shadows and sum cleared. Timer is idle and zero in S_IDLE.
- Rx_En_Sig: 0 in reset, 1 from first clock edge after reset release, held 1 thereafter.
- Frame_Cmd/Frame_Arg/Err_Code hold until next good frame / next error.

## Timing
- Reset values: Rx_En_Sig=0, Frame_Cmd=8'h00, Frame_Arg=16'h0000, Frame_Valid=0, Frame_Err=0, Err_Code=2'b00, state S_IDLE, timer 0, sum 0.
- Latency: Frame_Valid/Frame_Err asserted the cycle after the Rx_Done_Sig of CHK byte; Frame_Cmd/Frame_Arg updated in that same cycle.
- Timeout: Frame_Err asserted exactly GAP_CYCLES cycles after the last accepted Rx_Done_Sig.
- Simultaneous Rx_Done_Sig and timer expiry: byte wins; timer reloads, no error.
- Frame_Valid and Frame_Err never high in the same cycle.
- Reset mid-frame: immediate return to reset values; partial frame lost, no strobe.
- Back-to-back frames with zero idle supported (Rx_Done_Sig spacing ≥ 1 cycle).

## Structure
- Shared package: HDR_BYTE default, state encodings, Err_Code constants (ERR_CHK=2'b01, ERR_GAP=2'b10).
- One sub-module: rx_gap_timer (clk, reset, clear, run, expire), 13-bit counter sized from GAP_CYCLES.
- Parser FSM, shadow registers, and checksum accumulator in the top.

## Test plan
- Bytes AA 01 12 34 47 -> Frame_Valid pulse, Frame_Cmd=01, Frame_Arg=1234, Err_Code stays 00.
- Bytes AA 01 12 34 48 -> Frame_Err pulse, Err_Code=01, Frame_Cmd/Frame_Arg keep previous values.
- Bytes 55 00 AA 80 90 F0 00 (sum wrap 0x200) -> 55, 00 ignored, Frame_Valid, Cmd=80, Arg=90F0.
- AA 01 then silence -> Frame_Err exactly 7680 cycles after second strobe, Err_Code=10; following AA 02 00 00 02 -> Frame_Valid, Cmd=02.
- Byte strobe landing on cycle 7680 of gap -> no error, frame completes normally.
- reset asserted after AA 01 12, then AA 03 00 01 04 -> all outputs at reset values during reset, then Frame_Valid, Cmd=03, Arg=0001.
